// File: rtl/vga_pixel_fetch.sv
// Timing-to-pixel stage: pops one frame-buffer word per active VTC cycle, aligns it with
// 2-cycle-delayed syncs, and substitutes a fill colour after a FIFO underrun until the next vsync.
module vga_pixel_fetch #(
  parameter int                   PIX_WIDTH  = 12,
  parameter logic [PIX_WIDTH-1:0] FILL_COLOR = 12'hF00,
  parameter int                   CNT_WIDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_vsync,
  input  logic                 i_hsync,
  input  logic                 i_active,
  input  logic [PIX_WIDTH-1:0] i_pix_data,
  input  logic                 i_pix_empty,
  output logic                 o_pix_rd,
  output logic                 o_fifo_flush,
  output logic                 o_vsync,
  output logic                 o_hsync,
  output logic                 o_de,
  output logic [PIX_WIDTH-1:0] o_rgb,
  output logic                 o_underflow,
  output logic [CNT_WIDTH-1:0] o_underflow_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_UNDERRUN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   vsync_q, vsync_d;
  logic                   vs_rise;
  logic                   pix_rd;
  logic                   flush_q, flush_d;
  logic                   underflow_q, underflow_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic                   s1_vsync_q, s1_vsync_d;
  logic                   s1_hsync_q, s1_hsync_d;
  logic                   s1_active_q, s1_active_d;
  logic                   s1_rd_q, s1_rd_d;
  logic                   s1_fill_q, s1_fill_d;

  logic                   vsync_out_q, vsync_out_d;
  logic                   hsync_out_q, hsync_out_d;
  logic                   de_q, de_d;
  logic [PIX_WIDTH-1:0]   rgb_q, rgb_d;

  assign vsync_d = i_vsync;
  assign vs_rise = i_vsync & ~vsync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (vs_rise) state_d = ST_RUN;
      ST_RUN:      if (!vs_rise && i_active && i_pix_empty) state_d = ST_UNDERRUN;
      ST_UNDERRUN: if (vs_rise) state_d = ST_RUN;
      default:     state_d = ST_IDLE;
    endcase
  end

  // A vsync edge never coincides with a pop, even under illegal VTC timing.
  always_comb begin
    pix_rd      = (state_q == ST_RUN) && i_active && !i_pix_empty && !vs_rise;
    flush_d     = vs_rise && (state_q != ST_RUN);
    underflow_d = (state_q == ST_RUN) && (state_d == ST_UNDERRUN);
    cnt_d       = cnt_q;
    if (underflow_d && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    s1_vsync_d  = i_vsync;
    s1_hsync_d  = i_hsync;
    s1_active_d = i_active;
    s1_rd_d     = pix_rd;
    s1_fill_d   = i_active & ~pix_rd;
    vsync_out_d = s1_vsync_q;
    hsync_out_d = s1_hsync_q;
    de_d        = s1_active_q;
    // FIFO read data arrives the cycle after the pop, i.e. while stage 1 holds rd_fired.
    if (s1_rd_q) begin
      rgb_d = i_pix_data;
    end else if (s1_fill_q) begin
      rgb_d = FILL_COLOR;
    end else begin
      rgb_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vsync_q     <= 1'b0;
      flush_q     <= 1'b0;
      underflow_q <= 1'b0;
      cnt_q       <= '0;
      s1_vsync_q  <= 1'b0;
      s1_hsync_q  <= 1'b0;
      s1_active_q <= 1'b0;
      s1_rd_q     <= 1'b0;
      s1_fill_q   <= 1'b0;
      vsync_out_q <= 1'b0;
      hsync_out_q <= 1'b0;
      de_q        <= 1'b0;
      rgb_q       <= '0;
    end else begin
      vsync_q     <= vsync_d;
      flush_q     <= flush_d;
      underflow_q <= underflow_d;
      cnt_q       <= cnt_d;
      s1_vsync_q  <= s1_vsync_d;
      s1_hsync_q  <= s1_hsync_d;
      s1_active_q <= s1_active_d;
      s1_rd_q     <= s1_rd_d;
      s1_fill_q   <= s1_fill_d;
      vsync_out_q <= vsync_out_d;
      hsync_out_q <= hsync_out_d;
      de_q        <= de_d;
      rgb_q       <= rgb_d;
    end
  end

  assign o_pix_rd        = pix_rd;
  assign o_fifo_flush    = flush_q;
  assign o_underflow     = underflow_q;
  assign o_underflow_cnt = cnt_q;
  assign o_vsync         = vsync_out_q;
  assign o_hsync         = hsync_out_q;
  assign o_de            = de_q;
  assign o_rgb           = rgb_q;

endmodule
